// File: rtl/add_pipe_if.sv
// Handshake bundle for add_pipe: operand side (in_*) and result side (out_*).
// The producer/consumer drives through master; the adder itself plugs in as slave.
interface add_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf
    );
endinterface

// File: rtl/add_pipe.sv
// Pipelined add/subtract: the carry chain is cut into STAGES chunks, one register
// stage per chunk, with a single global enable driven by downstream back-pressure.
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic       clk,
    input logic       rst,
    add_pipe_if.slave bus
);
    localparam int STG_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int CHUNK    = WIDTH / STG_SAFE;

    if ((STAGES < 1) || ((WIDTH % STG_SAFE) != 0)) begin : g_param_check
        $error("add_pipe: STAGES (%0d) must be >= 1 and divide WIDTH (%0d)", STAGES, WIDTH);
    end

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
    } step_t;

    // Adds chunk k of a and b plus cin, dropping the chunk result into s.
    function automatic step_t add_chunk(input logic [WIDTH-1:0] a, b, s,
                                        input logic cin, input int k);
        logic [CHUNK:0] part;
        step_t          r;
        part = {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]}
             + (CHUNK+1)'(cin);
        r.s = s;
        r.s[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        r.c = part[CHUNK];
        return r;
    endfunction

    // Same-sign operands producing an opposite-sign result have wrapped.
    function automatic logic ovf_flag(input logic signed [WIDTH-1:0] a, b, s);
        return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
    endfunction

    logic             vld_p [STAGES];
    logic             cy_p  [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];
    step_t            stg   [STAGES];
    logic [WIDTH-1:0] b_mod;
    logic             en;

    assign en           = !vld_p[STAGES-1] || bus.out_ready;
    assign bus.in_ready = en && !rst;
    assign b_mod        = bus.in_sub ? ~bus.in_b : bus.in_b;

    always_comb begin
        stg[0] = add_chunk(bus.in_a, b_mod, '0, bus.in_sub, 0);
        for (int k = 1; k < STAGES; k++) begin
            stg[k] = add_chunk(a_p[k-1], b_p[k-1], s_p[k-1], cy_p[k-1], k);
        end
    end

    // Every stage, bubbles included, advances together only when en is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                cy_p[k]  <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
            end
        end else if (en) begin
            // stage 0 boundary: operands enter with B already conditioned
            vld_p[0] <= bus.in_valid && bus.in_ready;
            a_p[0]   <= bus.in_a;
            b_p[0]   <= b_mod;
            s_p[0]   <= stg[0].s;
            cy_p[0]  <= stg[0].c;
            // stages 1..STAGES-1 boundary: one more chunk resolved per stage
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
                a_p[k]   <= a_p[k-1];
                b_p[k]   <= b_p[k-1];
                s_p[k]   <= stg[k].s;
                cy_p[k]  <= stg[k].c;
            end
        end
    end

    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.out_sum   = s_p[STAGES-1];
    assign bus.out_carry = cy_p[STAGES-1];
    assign bus.out_ovf   = ovf_flag(a_p[STAGES-1], b_p[STAGES-1], s_p[STAGES-1]);
endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: three instances (STAGES 4, 1, 32) share a clock and reset;
// a queue of expected results is filled at acceptance and drained at output.
`timescale 1ns/1ps
module tb_add_pipe;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         dv, dsub, drdy;
    logic [W-1:0] da, db;
    int           sel;
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    exp_t         exp_q[$];

    add_pipe_if #(.WIDTH(W)) if4 ();
    add_pipe_if #(.WIDTH(W)) if1 ();
    add_pipe_if #(.WIDTH(W)) if32 ();

    add_pipe #(.WIDTH(W), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    add_pipe #(.WIDTH(W), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    add_pipe #(.WIDTH(W), .STAGES(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    assign if4.in_valid   = (sel == 4) && dv;
    assign if4.in_a       = da;
    assign if4.in_b       = db;
    assign if4.in_sub     = dsub;
    assign if4.out_ready  = (sel == 4) ? drdy : 1'b1;
    assign if1.in_valid   = (sel == 1) && dv;
    assign if1.in_a       = da;
    assign if1.in_b       = db;
    assign if1.in_sub     = dsub;
    assign if1.out_ready  = (sel == 1) ? drdy : 1'b1;
    assign if32.in_valid  = (sel == 32) && dv;
    assign if32.in_a      = da;
    assign if32.in_b      = db;
    assign if32.in_sub    = dsub;
    assign if32.out_ready = (sel == 32) ? drdy : 1'b1;

    logic         o_valid, o_inrdy, o_c, o_o;
    logic [W-1:0] o_sum;
    always_comb begin
        o_valid = if4.out_valid;
        o_inrdy = if4.in_ready;
        o_sum   = if4.out_sum;
        o_c     = if4.out_carry;
        o_o     = if4.out_ovf;
        if (sel == 1) begin
            o_valid = if1.out_valid;
            o_inrdy = if1.in_ready;
            o_sum   = if1.out_sum;
            o_c     = if1.out_carry;
            o_o     = if1.out_ovf;
        end else if (sel == 32) begin
            o_valid = if32.out_valid;
            o_inrdy = if32.in_ready;
            o_sum   = if32.out_sum;
            o_c     = if32.out_carry;
            o_o     = if32.out_ovf;
        end
    end

    // Reference: wide signed arithmetic for overflow, magnitude compare for borrow.
    function automatic exp_t model(input logic [W-1:0] a, b, input logic sub);
        exp_t   r;
        longint sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = sub ? sa - sb : sa + sb;
        r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (sub) begin
            r.sum = a - b;
            r.c   = (a >= b);
        end else begin
            {r.c, r.sum} = {1'b0, a} + {1'b0, b};
        end
        return r;
    endfunction

    // One clock: observe just before the edge what will transfer, then cross it.
    task automatic tick(output logic fin, output logic fout, output logic v,
                        output logic [W-1:0] s, output logic c, output logic o,
                        output logic ir);
        #1;
        ir   = o_inrdy;
        v    = o_valid;
        fin  = dv && o_inrdy;
        fout = o_valid && drdy;
        s    = o_sum;
        c    = o_c;
        o    = o_o;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_one(input int which, input logic [W-1:0] a, b, input logic sub,
                           output int lat, output logic [W-1:0] s, output logic c, o);
        logic         fin, fout, v, ir, cc, oo;
        logic [W-1:0] ss;
        sel = which; drdy = 1'b1; dv = 1'b1; da = a; db = b; dsub = sub;
        tick(fin, fout, v, ss, cc, oo, ir);
        dv = 1'b0;
        lat = -1; s = '0; c = 1'b0; o = 1'b0;
        if (fin) begin
            for (int k = 1; k <= 80 && lat < 0; k++) begin
                tick(fin, fout, v, ss, cc, oo, ir);
                if (fout) begin
                    lat = k; s = ss; c = cc; o = oo;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic         fin, fout, v, ir, c, o;
        logic [W-1:0] s;
        rst = 1'b1; dv = 1'b0; drdy = 1'b1; sel = 4;
        tick(fin, fout, v, s, c, o, ir);
        tick(fin, fout, v, s, c, o, ir);
        n_checks++;
        if (ir !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", ir); end
        n_checks++;
        if ({if4.out_valid, if1.out_valid, if32.out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_out_valid got %b%b%b want 000", if4.out_valid, if1.out_valid, if32.out_valid);
        end
        n_checks++;
        if ({if4.out_sum, if4.out_carry, if4.out_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got sum %h c %b o %b want zeros", if4.out_sum, if4.out_carry, if4.out_ovf);
        end
        n_checks++;
        if ({if32.out_sum, if32.out_carry, if32.out_ovf, if1.out_sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_s1_s32 got %h %b %b %h want zeros", if32.out_sum, if32.out_carry, if32.out_ovf, if1.out_sum);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors(input int which);
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic         vs [5];
        exp_t         ve [5];
        exp_t         e;
        int           lat;
        logic [W-1:0] s;
        logic         c, o;
        va = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000};
        vb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'd7, 32'h0000_0001};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ve = '{'{32'h0000_0100, 1'b0, 1'b0}, '{32'h0000_0000, 1'b1, 1'b0},
               '{32'h8000_0000, 1'b0, 1'b1}, '{32'hFFFF_FFFE, 1'b0, 1'b0},
               '{32'h7FFF_FFFF, 1'b1, 1'b1}};
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ve[i]);
            run_one(which, va[i], vb[i], vs[i], lat, s, c, o);
            n_checks++;
            if (lat != which) begin
                n_fail++;
                $display("FAIL latency S%0d vec%0d got %0d want %0d", which, i, lat, which);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (s !== e.sum) begin n_fail++; $display("FAIL sum S%0d vec%0d got %h want %h", which, i, s, e.sum); end
            n_checks++;
            if (c !== e.c) begin n_fail++; $display("FAIL carry S%0d vec%0d got %b want %b", which, i, c, e.c); end
            n_checks++;
            if (o !== e.o) begin n_fail++; $display("FAIL ovf S%0d vec%0d got %b want %b", which, i, o, e.o); end
        end
    endtask

    task automatic test_back_to_back();
        logic         fin, fout, v, ir, c, o, held, hc, ho;
        logic [W-1:0] s, hs;
        exp_t         e;
        int           sent, got, extra;
        sel = 4; held = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
        sent = 0; got = 0; extra = 0;
        exp_q.delete();
        da = $urandom; db = $urandom; dsub = 1'($urandom_range(0, 1));
        for (int t = 0; t < 200 && got < 16; t++) begin
            drdy = !(t inside {6, 7, 8, 11});
            dv   = (sent < 16);
            tick(fin, fout, v, s, c, o, ir);
            if (held) begin
                n_checks++;
                if ({s, c, o} !== {hs, hc, ho}) begin
                    n_fail++;
                    $display("FAIL stall_stable t%0d got %h/%b/%b want %h/%b/%b", t, s, c, o, hs, hc, ho);
                end
            end
            if (v && !drdy) begin
                n_checks++;
                if (ir !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready t%0d got %b want 0", t, ir); end
            end
            held = v && !drdy; hs = s; hc = c; ho = o;
            if (fout) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_result t%0d got %h want none", t, s);
                end else begin
                    e = exp_q.pop_front();
                    if ({s, c, o} !== {e.sum, e.c, e.o}) begin
                        n_fail++;
                        $display("FAIL b2b_result #%0d got %h/%b/%b want %h/%b/%b", got, s, c, o, e.sum, e.c, e.o);
                    end
                end
                got++;
            end
            if (fin) begin
                exp_q.push_back(model(da, db, dsub));
                sent++;
                da = $urandom; db = $urandom; dsub = 1'($urandom_range(0, 1));
            end
        end
        n_checks++;
        if (got != 16 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count got %0d results (%0d pending) want 16 (0)", got, exp_q.size());
        end
        dv = 1'b0; drdy = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick(fin, fout, v, s, c, o, ir);
            if (fout) extra++;
        end
        n_checks++;
        if (extra != 0) begin n_fail++; $display("FAIL b2b_duplicate got %0d extra want 0", extra); end
    endtask

    task automatic test_reset_flush();
        logic         fin, fout, v, ir, c, o;
        logic [W-1:0] s;
        int           acc, stale, lat;
        sel = 4; drdy = 1'b1; dv = 1'b1; acc = 0; stale = 0;
        for (int i = 0; i < 3; i++) begin
            da = 32'h1000_0000 * (i + 1); db = 32'd3; dsub = 1'b0;
            tick(fin, fout, v, s, c, o, ir);
            if (fin) acc++;
            if (fout) stale++;
        end
        n_checks++;
        if (acc != 3) begin n_fail++; $display("FAIL flush_accept got %0d want 3", acc); end
        dv = 1'b0; rst = 1'b1;
        tick(fin, fout, v, s, c, o, ir);
        if (fout) stale++;
        n_checks++;
        if (ir !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", ir); end
        rst = 1'b0;
        tick(fin, fout, v, s, c, o, ir);
        n_checks++;
        if (v !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", v); end
        for (int t = 0; t < 6; t++) begin
            tick(fin, fout, v, s, c, o, ir);
            if (fout) stale++;
        end
        n_checks++;
        if (stale != 0) begin n_fail++; $display("FAIL flush_stale got %0d want 0", stale); end
        exp_q.delete();
        exp_q.push_back(model(32'h1234_5678, 32'h1111_1111, 1'b0));
        run_one(4, 32'h1234_5678, 32'h1111_1111, 1'b0, lat, s, c, o);
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL flush_latency got %0d want 4", lat); end
        n_checks++;
        if (exp_q.size() != 1 || s !== exp_q[0].sum || c !== exp_q[0].c || o !== exp_q[0].o) begin
            n_fail++;
            $display("FAIL flush_result got %h/%b/%b want %h", s, c, o, 32'h2345_6789);
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; dv = 1'b0; drdy = 1'b1; dsub = 1'b0; da = '0; db = '0; sel = 4;
        @(posedge clk);
        #1;
        test_reset();
        test_vectors(4);
        test_back_to_back();
        test_reset_flush();
        test_vectors(1);
        test_vectors(32);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
